// File: rtl/sparse_match_pkg.sv
// Shared constants, FSM state type and slot-packing helper for the sparse
// match scheduler.
package sparse_match_pkg;

    localparam int DEF_BITMASK_LENGTH = 16;
    localparam int DEF_INDEX_BITWIDTH = 5;
    localparam int DEF_MAX_NUM_OUTPUT = 2;
    localparam int DEF_COUNT_BITWIDTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // LSB of slot k in a flat bus laid out as [(k+1)*W-1 -: W].
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/match_window_finder.sv
// Combinational search for the lowest MAX_NUM_OUTPUT mutual ones at or above
// the cursor, plus the resume point and a flag for ones left beyond it.
module match_window_finder
    import sparse_match_pkg::*;
#(
    parameter int BITMASK_LENGTH = DEF_BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH = DEF_INDEX_BITWIDTH,
    parameter int MAX_NUM_OUTPUT = DEF_MAX_NUM_OUTPUT,
    parameter int COUNT_BITWIDTH = DEF_COUNT_BITWIDTH
) (
    input  logic [BITMASK_LENGTH-1:0]                mutual_i,
    input  logic [INDEX_BITWIDTH-1:0]                cursor_i,
    output logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] pos_o,
    output logic [COUNT_BITWIDTH-1:0]                count_o,
    output logic [INDEX_BITWIDTH-1:0]                next_o,
    output logic                                     more_o
);

    int taken;

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        taken  = 0;
        pos_o  = '0;
        next_o = INDEX_BITWIDTH'(BITMASK_LENGTH);
        more_o = 1'b0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            if (mutual_i[i] && (i >= int'(cursor_i))) begin
                if (taken < MAX_NUM_OUTPUT) begin
                    pos_o[slot_lsb(taken, INDEX_BITWIDTH) +: INDEX_BITWIDTH] = INDEX_BITWIDTH'(i);
                    next_o = INDEX_BITWIDTH'(i + 1);
                    taken  = taken + 1;
                end else begin
                    // Any one found after the window is full lies at or above next.
                    more_o = 1'b1;
                end
            end
        end
        count_o = COUNT_BITWIDTH'(taken);
    end

endmodule

// File: rtl/sparse_match_scheduler.sv
// Accepts one weight/activation bitmask block and walks the mutual mask,
// emitting up to MAX_NUM_OUTPUT matched positions with dense offsets per beat.
module sparse_match_scheduler
    import sparse_match_pkg::*;
#(
    parameter int BITMASK_LENGTH = DEF_BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH = DEF_INDEX_BITWIDTH,
    parameter int MAX_NUM_OUTPUT = DEF_MAX_NUM_OUTPUT,
    parameter int COUNT_BITWIDTH = DEF_COUNT_BITWIDTH
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [BITMASK_LENGTH-1:0]                in_bitmask_w,
    input  logic [BITMASK_LENGTH-1:0]                in_bitmask_a,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [COUNT_BITWIDTH-1:0]                out_num,
    output logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] out_pos,
    output logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] out_offset_w,
    output logic [MAX_NUM_OUTPUT*INDEX_BITWIDTH-1:0] out_offset_a,
    output logic                                     out_last
);

    localparam int SLOT_BUS = MAX_NUM_OUTPUT * INDEX_BITWIDTH;

    state_e                    state_q, state_d;
    logic [INDEX_BITWIDTH-1:0] cursor_q, cursor_d;
    logic [BITMASK_LENGTH-1:0] mask_w_q, mask_w_d;
    logic [BITMASK_LENGTH-1:0] mask_a_q, mask_a_d;
    logic [BITMASK_LENGTH-1:0] mutual_q, mutual_d;

    logic [SLOT_BUS-1:0]       win_pos;
    logic [COUNT_BITWIDTH-1:0] win_count;
    logic [INDEX_BITWIDTH-1:0] win_next;
    logic                      win_more;

    logic [INDEX_BITWIDTH-1:0] pre_w [BITMASK_LENGTH];
    logic [INDEX_BITWIDTH-1:0] pre_a [BITMASK_LENGTH];
    logic [SLOT_BUS-1:0]       off_w_c, off_a_c;
    logic                      run;

    match_window_finder #(
        .BITMASK_LENGTH(BITMASK_LENGTH),
        .INDEX_BITWIDTH(INDEX_BITWIDTH),
        .MAX_NUM_OUTPUT(MAX_NUM_OUTPUT),
        .COUNT_BITWIDTH(COUNT_BITWIDTH)
    ) u_finder (
        .mutual_i(mutual_q),
        .cursor_i(cursor_q),
        .pos_o   (win_pos),
        .count_o (win_count),
        .next_o  (win_next),
        .more_o  (win_more)
    );

    // Prefix popcounts from bit 0, independent of the cursor.
    always_comb begin
        pre_w[0] = '0;
        pre_a[0] = '0;
        for (int i = 1; i < BITMASK_LENGTH; i++) begin
            pre_w[i] = pre_w[i-1] + INDEX_BITWIDTH'(mask_w_q[i-1]);
            pre_a[i] = pre_a[i-1] + INDEX_BITWIDTH'(mask_a_q[i-1]);
        end
    end

    always_comb begin
        off_w_c = '0;
        off_a_c = '0;
        for (int k = 0; k < MAX_NUM_OUTPUT; k++) begin
            for (int i = 0; i < BITMASK_LENGTH; i++) begin
                if ((k < int'(win_count)) &&
                    (win_pos[slot_lsb(k, INDEX_BITWIDTH) +: INDEX_BITWIDTH] == INDEX_BITWIDTH'(i))) begin
                    off_w_c[slot_lsb(k, INDEX_BITWIDTH) +: INDEX_BITWIDTH] = pre_w[i];
                    off_a_c[slot_lsb(k, INDEX_BITWIDTH) +: INDEX_BITWIDTH] = pre_a[i];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        mask_w_d = mask_w_q;
        mask_a_d = mask_a_q;
        mutual_d = mutual_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_w_d = in_bitmask_w;
                    mask_a_d = in_bitmask_a;
                    mutual_d = in_bitmask_w & in_bitmask_a;
                    cursor_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (!win_more) begin
                        state_d = IDLE;
                    end else begin
                        cursor_d = win_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            mask_w_q <= '0;
            mask_a_q <= '0;
            mutual_q <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            mask_w_q <= mask_w_d;
            mask_a_q <= mask_a_d;
            mutual_q <= mutual_d;
        end
    end

    // Outputs depend on registered state only; data is forced to zero when idle.
    assign run          = (state_q == RUN);
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = run;
    assign out_num      = run ? win_count : '0;
    assign out_pos      = run ? win_pos : '0;
    assign out_offset_w = run ? off_w_c : '0;
    assign out_offset_a = run ? off_a_c : '0;
    assign out_last     = run & ~win_more;

endmodule

// File: doc/sparse_match_scheduler.md
# sparse_match_scheduler

Sequencer for sparse weight/activation matching. Accepts one block of weight and activation bitmasks, computes the mutual mask, then walks it over successive cycles. Each output beat carries up to MAX_NUM_OUTPUT matched positions, plus each position's compressed offset into the dense weight stream and into the dense activation stream. It sits between the bitmask fetch path and the sparse MAC buffer-update stage, and replaces host-driven iteration of startIndex/nextStartIndex.

## Interface
- BITMASK_LENGTH, 16, positions per bitmask block
- INDEX_BITWIDTH, 5, position/offset width; must represent BITMASK_LENGTH
- MAX_NUM_OUTPUT, 2, max matched positions per beat (≥1)
- COUNT_BITWIDTH, 2, width of out_num; must represent MAX_NUM_OUTPUT
- Clock and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  mask block offered
- in_ready  out  1  block accepted when in_valid & in_ready
- in_bitmask_w  in  BITMASK_LENGTH  weight mask, bit i = position i
- in_bitmask_a  in  BITMASK_LENGTH  activation mask
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid & out_ready
- out_num  out  COUNT_BITWIDTH  matched positions in this beat (0..MAX_NUM_OUTPUT)
- out_pos  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  slot k at [(k+1)*INDEX_BITWIDTH-1 -: INDEX_BITWIDTH]
- out_offset_w  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  per slot: popcount(mask_w[pos-1:0])
- out_offset_a  out  MAX_NUM_OUTPUT*INDEX_BITWIDTH  per slot: popcount(mask_a[pos-1:0])
- out_last  out  1  final beat of the block

## Operation
- FSM states: IDLE, RUN.
- IDLE: in_ready=1. On input handshake: register mask_w, mask_a, mutual=w&a; cursor←0; go to RUN.
- RUN: in_ready=0. The beat is formed from the registered state only. It takes the lowest min(MAX_NUM_OUTPUT, remaining) mutual ones at positions ≥cursor, in ascending order, with slot 0 as the lowest position.
- next = last emitted position+1. When out_num=0, next = BITMASK_LENGTH.
- out_last = 1 when there are no mutual ones at positions ≥ next.
- On output handshake:
  - If out_last: go to IDLE.
  - Otherwise: cursor←next.
- Without a handshake, all state and outputs hold, so outputs stay stable under backpressure.
- Empty mutual mask: exactly one beat with out_num=0, out_last=1, all slots zero.
- Unused slots (k ≥ out_num) are driven to zero. All out_* data are zero when out_valid=0.
- Offsets are independent of cursor: each is a full prefix popcount from bit 0. Width is INDEX_BITWIDTH; the maximum value is BITMASK_LENGTH-1, so there is no overflow.
- When a beat fills all slots exactly, out_last is still computed from the remaining ones; no empty trailing beat is emitted.

## Timing
- Reset (asynchronous assert): state=IDLE, cursor=0, mask registers=0. Outputs: in_ready=1, out_valid=0, out_num=0, out_pos/out_offset_*=0, out_last=0.
- First beat has out_valid=1 in the cycle after input acceptance (1-cycle latency).
- Throughput is one beat per cycle while out_ready=1. A block with M mutual ones takes max(1, ceil(M/MAX_NUM_OUTPUT)) beats.
- No combinational path from in_* or out_ready to any out_* data. in_ready is a function of state only.
- The next block can be accepted in the cycle after the last-beat handshake; there is no same-cycle overlap.
- in_valid while in RUN is ignored and must be held by the source.
- Reset mid-block discards the block. in_ready=1 from the first cycle after reset deassertion.

## Structure
- Package sparse_match_pkg holds:
  - default parameter constants;
  - state enum typedef (IDLE, RUN);
  - slot-packing helper function for the [(k+1)*W-1 -: W] layout.
- Sub-module match_window_finder is combinational.
  - Inputs: mutual mask, cursor.
  - Outputs: positions, count, next, remaining-after-next flag.
  - It is instantiated once.
- Prefix popcounts of mask_w and mask_a live in the top level and are indexed by slot position.

## Test plan
- w=16'hFFFF, a=16'h0000 → one beat: num=0, last=1, all slots 0; in_ready=1 the following cycle.
- w=16'hF0F0, a=16'h00FF (mutual positions 4–7) → two beats:
  - beat 1: pos{4,5}, off_w{0,1}, off_a{4,5}, last=0;
  - beat 2: pos{6,7}, off_w{2,3}, off_a{6,7}, last=1.
- w=a=16'h8009 → two beats:
  - beat 1: num=2, pos{0,3}, off_w/off_a{0,1}, last=0;
  - beat 2: num=1, pos{15,0}, off_w/off_a{2,0}, last=1.
- Repeat the second scenario with out_ready low for 5 cycles during beat 1 → beat 1 outputs unchanged throughout; beat 2 follows only after the handshake.
- Assert reset during beat 1 of the second scenario → out_valid=0 and in_ready=1 immediately. A new block w=a=16'h0001 then yields pos{0}, num=1, last=1.
- Hold in_valid high during RUN with a different mask → not accepted until the cycle after the last handshake. Its beats are then correct for the new mask.
